// File: rtl/arb_pkg.sv
// +------------------------------------------------------------------+
// | arb_pkg: shared state encoding and sizing for req_pri_arbiter     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pri_pick.sv
// +------------------------------------------------------------------+
// | pri_pick: combinational winner select, search base-1, base-2 ... |
// | wrapping modulo N_REQ and ending at base. Rev 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

module pri_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = base - IDX_W'(k);
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/req_pri_arbiter.sv
// +------------------------------------------------------------------+
// | req_pri_arbiter: 4-way grant/hold/release arbiter with hold limit |
// | Optional macro ROUND_ROBIN_EN rotates priority. Rev 1.0           |
// +------------------------------------------------------------------+
`default_nettype none

module req_pri_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [IDX_W-1:0] pick_base;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    assign pick_base = rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && enable && pick_valid) begin
            rr_ptr_d = pick_idx;
        end
    end
`else
    assign pick_base = '0;
`endif

    pri_pick u_pri_pick (
        .req    (req),
        .base   (pick_base),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (enable && pick_valid) begin
                    grant_d     = N_REQ'(1) << pick_idx;
                    grant_idx_d = pick_idx;
                    hold_cnt_d  = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Abort beats completion, completion beats the hold limit.
                if (!enable) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (done || !req[grant_idx_q]) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end else if (hold_cnt_q == HOLD_LIMIT) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_req_pri_arbiter.sv
// +------------------------------------------------------------------+
// | tb_req_pri_arbiter: directed checks of the default fixed-priority |
// | build of req_pri_arbiter (MAX_HOLD=8). Rev 1.0                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_req_pri_arbiter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    req_pri_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs against an expected grant vector and timeout.
    task automatic check_out(input string tag, input logic [3:0] exp_grant, input logic exp_to);
        check({tag, ".grant"}, {28'd0, grant}, {28'd0, exp_grant});
        check({tag, ".valid"}, {31'd0, grant_valid}, {31'd0, |exp_grant});
        check({tag, ".timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        req    = 4'b1111;
        done   = 1'b0;
        tick();
        tick();
        check_out("reset", 4'b0000, 1'b0);
        check("reset.idx", {30'd0, grant_idx}, 32'd0);

        rst    = 1'b0;
        enable = 1'b1;
        tick();
        check_out("first_grant", 4'b1000, 1'b0);
        check("first_grant.idx", {30'd0, grant_idx}, 32'd3);

        // Requester 3 withdraws; index is retained through release and idle.
        req = 4'b0000;
        tick();
        check_out("withdraw3.release", 4'b0000, 1'b0);
        check("withdraw3.idx_hold", {30'd0, grant_idx}, 32'd3);
        tick();
        check_out("withdraw3.idle", 4'b0000, 1'b0);

        // Fixed priority picks 2 over 1; done on the third grant cycle.
        req = 4'b0110;
        tick();
        check_out("prio.c1", 4'b0100, 1'b0);
        check("prio.idx", {30'd0, grant_idx}, 32'd2);
        tick();
        check_out("prio.c2", 4'b0100, 1'b0);
        tick();
        check_out("prio.c3", 4'b0100, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_out("done.release", 4'b0000, 1'b0);
        tick();
        check_out("done.idle", 4'b0000, 1'b0);
        tick();
        check_out("done.regrant", 4'b0100, 1'b0);

        // Higher request mid-grant does not preempt; then requester 2 drops.
        req = 4'b1100;
        tick();
        check_out("nopreempt", 4'b0100, 1'b0);
        req = 4'b0001;
        tick();
        check_out("drop2.release", 4'b0000, 1'b0);
        tick();
        tick();
        check_out("req0.grant", 4'b0001, 1'b0);
        check("req0.idx", {30'd0, grant_idx}, 32'd0);
        req = 4'b0000;
        tick();
        check_out("withdraw0.release", 4'b0000, 1'b0);
        tick();

        // Hold limit: eight grant cycles, then timeout on the release cycle.
        req = 4'b0010;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_out($sformatf("hold.c%0d", i + 1), 4'b0010, 1'b0);
            tick();
        end
        check_out("hold.timeout", 4'b0000, 1'b1);
        tick();
        check_out("hold.after_pulse", 4'b0000, 1'b0);
        tick();
        check_out("hold2.c1", 4'b0010, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        check_out("hold2.c8", 4'b0010, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_out("done_at_limit", 4'b0000, 1'b0);
        tick();
        tick();
        check_out("abort.pre", 4'b0010, 1'b0);

        // Enable abort goes straight to idle with no pulse and blocks grants.
        enable = 1'b0;
        tick();
        check_out("abort", 4'b0000, 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("disabled.%0d", i), 4'b0000, 1'b0);
        end
        enable = 1'b1;
        tick();
        check_out("reenable", 4'b1000, 1'b0);

        // All requesting with done each grant: fixed priority always picks 3.
        for (int i = 0; i < 4; i++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            check_out($sformatf("fixed.rel%0d", i), 4'b0000, 1'b0);
            tick();
            tick();
            check($sformatf("fixed.idx%0d", i), {30'd0, grant_idx}, 32'd3);
            check($sformatf("fixed.grant%0d", i), {28'd0, grant}, 32'h8);
        end

        // Reset mid-grant has priority over everything.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("rst_mid", 4'b0000, 1'b0);
        check("rst_mid.idx", {30'd0, grant_idx}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
